bsg_fsb_hop_out_rr_arb: RTL and testbench

BSG_FSB_HOP_OUT_RR_ARB -- requirements
Module: bsg_fsb_hop_out_rr_arb

---
 rtl/bsg_fsb_hop_out_rr_arb.sv | 150 +++++++++++++++
 tb/tb_bsg_fsb_hop_out_rr_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_hop_out_rr_arb.sv
// bsg_fsb_hop_out_rr_arb
//   Round-robin arbiter that merges els_p requesters into one output stream.
//   Each cycle it grants at most one valid requester and pushes its word into
//   a 2-entry output FIFO. The downstream side drains that FIFO with a
//   valid/ready handshake.
//
// Parameters
//   width_p  payload width in bits
//   els_p    number of requesters (2..8)
//
// Ports
//   clk_i        clock; all state changes on the rising edge
//   reset_n_i    asynchronous active-low reset
//   v_i          per-requester valid
//   data_i       requester k's word in bits [k*width_p +: width_p]
//   yumi_o       one-hot-or-zero acceptance of requester k this cycle
//   v_o          output word valid
//   data_o       output word
//   ready_i      downstream ready; a word transfers on v_o & ready_i
//   stall_cnt_o  count of cycles with v_o=1 and ready_i=0
//
// Configuration
//   BSG_FSB_HOP_OUT_STALL_CNT_EN  when defined, stall_cnt_o is a saturating
//                                 16-bit counter; otherwise it is tied to 0.

module bsg_fsb_hop_out_rr_arb #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i,
    output logic [15:0]                stall_cnt_o
);

    localparam int lg_els_lp = $clog2(els_p);

    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic [lg_els_lp-1:0] last_q, last_d;
    logic [width_p-1:0]   mem_q [2];

    logic                 grant_v;
    logic [lg_els_lp-1:0] grant_idx;
    logic [lg_els_lp:0]   probe;
    logic                 enq;
    logic                 deq;

    // Round-robin search starting one past the last winner. The probe is one
    // bit wider than an index so the wrap can be done by a single subtract,
    // which also handles els_p that are not powers of two.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = last_q;
        probe     = '0;
        if (!full_q) begin
            for (int i = 1; i <= els_p; i++) begin
                probe = {1'b0, last_q} + (lg_els_lp+1)'(i);
                if (probe >= (lg_els_lp+1)'(els_p)) begin
                    probe = probe - (lg_els_lp+1)'(els_p);
                end
                if (!grant_v && v_i[probe[lg_els_lp-1:0]]) begin
                    grant_v   = 1'b1;
                    grant_idx = probe[lg_els_lp-1:0];
                end
            end
        end
    end

    // Acceptance looks only at the registered full flag, never at ready_i.
    // Qualifying with reset keeps yumi_o quiet while reset is held.
    always_comb begin
        yumi_o = '0;
        if (grant_v && reset_n_i) begin
            yumi_o[grant_idx] = 1'b1;
        end
    end

    assign enq = grant_v;
    assign deq = ~empty_q & ready_i;

    always_comb begin
        head_d  = head_q ^ deq;
        tail_d  = tail_q ^ enq;
        full_d  = full_q;
        empty_d = empty_q;
        last_d  = grant_v ? grant_idx : last_q;
        case ({enq, deq})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = ~empty_q;
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = ~full_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            last_q  <= lg_els_lp'(els_p-1);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            last_q  <= last_d;
        end
    end

    // Storage is not reset; the flags alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[tail_q] <= data_i[grant_idx*width_p +: width_p];
        end
    end

    assign v_o    = ~empty_q;
    assign data_o = mem_q[head_q];

`ifdef BSG_FSB_HOP_OUT_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_q <= '0;
        end else if (!empty_q && !ready_i && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_fsb_hop_out_rr_arb.sv
// Testbench for bsg_fsb_hop_out_rr_arb (width_p=32, els_p=4).
// A scoreboard queue holds the words the arbiter is expected to accept, in
// order; they are popped and compared as the DUT hands them downstream.

module tb_bsg_fsb_hop_out_rr_arb;

    localparam int W = 32;
    localparam int E = 4;

`ifdef BSG_FSB_HOP_OUT_STALL_CNT_EN
    localparam logic [15:0] STALL5 = 16'd5;
`else
    localparam logic [15:0] STALL5 = 16'd0;
`endif

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic [E-1:0]   v_i;
    logic [E*W-1:0] data_i;
    logic [E-1:0]   yumi_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic           ready_i;
    logic [15:0]    stall_cnt_o;

    always #5 clk_i = ~clk_i;

    bsg_fsb_hop_out_rr_arb #(.width_p(W), .els_p(E)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .yumi_o      (yumi_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .ready_i     (ready_i),
        .stall_cnt_o (stall_cnt_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    int          m_last;
    logic [15:0] m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [E-1:0] rr_pick(input logic [E-1:0] v, input int last);
        for (int i = 1; i <= E; i++) begin
            int k;
            k = (last + i) % E;
            if (v[k]) return E'(1 << k);
        end
        return '0;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, then
    // let the model advance as the rising edge will.
    task automatic cycle(input logic [E-1:0] v, input logic rdy);
        logic [E-1:0] exp_y;
        int occ;
        @(negedge clk_i);
        v_i     = v;
        ready_i = rdy;
        for (int k = 0; k < E; k++) data_i[k*W +: W] = $urandom;
        #1;
        occ   = exp_q.size();
        exp_y = (occ < 2) ? rr_pick(v, m_last) : '0;
        chk("yumi_o", 32'(yumi_o), 32'(exp_y));
        chk("v_o", 32'(v_o), 32'(occ != 0));
        chk("stall_cnt_o", 32'(stall_cnt_o), 32'(m_stall));
        if (occ != 0 && rdy) begin
            chk("data_o", data_o, exp_q[0]);
            void'(exp_q.pop_front());
        end
        for (int k = 0; k < E; k++) begin
            if (exp_y[k]) begin
                exp_q.push_back(data_i[k*W +: W]);
                m_last = k;
            end
        end
`ifdef BSG_FSB_HOP_OUT_STALL_CNT_EN
        if (occ != 0 && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        v_i       = '1;
        ready_i   = 1'b1;
        #1;
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_yumi_o", 32'(yumi_o), 32'd0);
        chk("rst_stall", 32'(stall_cnt_o), 32'd0);
        @(negedge clk_i);
        v_i       = '0;
        reset_n_i = 1'b1;
        exp_q.delete();
        m_last  = E - 1;
        m_stall = '0;
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i       = '0;
        data_i    = '0;
        ready_i   = 1'b0;
        m_last    = E - 1;
        m_stall   = '0;
        do_reset();

        // Wrap search from last=3, then requester 0 wins over 3.
        cycle(4'b1000, 1'b1);
        chk("wrap_grant3", 32'(yumi_o), 32'h8);
        cycle(4'b1001, 1'b1);
        chk("after3_grant0", 32'(yumi_o), 32'h1);
        repeat (3) cycle(4'b0000, 1'b1);

        // All requesters held valid with ready: strict rotation from 0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1);
            chk("rotate", 32'(yumi_o), 32'(4'b0001 << (i % 4)));
        end
        repeat (3) cycle(4'b0000, 1'b1);

        // Backpressure: two grants fill the FIFO, then no grant even on the
        // dequeue cycle; a grant follows in the next cycle.
        cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0001, 1'b0);
        chk("full_no_grant", 32'(yumi_o), 32'h0);
        cycle(4'b0001, 1'b1);
        chk("full_deq_no_grant", 32'(yumi_o), 32'h0);
        cycle(4'b0001, 1'b0);
        chk("refill_grant", 32'(yumi_o), 32'h1);
        repeat (4) cycle(4'b0000, 1'b1);

        // Occupancy 1 with simultaneous enqueue and dequeue.
        cycle(4'b0010, 1'b0);
        cycle(4'b0100, 1'b1);
        chk("simul_grant", 32'(yumi_o), 32'h4);
        cycle(4'b0000, 1'b0);
        chk("simul_occ1", 32'(v_o), 32'd1);
        repeat (2) cycle(4'b0000, 1'b1);

        // Asynchronous reset mid-burst with two words queued.
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        @(posedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_v_o", 32'(v_o), 32'd0);
        chk("async_rst_yumi", 32'(yumi_o), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        v_i       = '0;
        exp_q.delete();
        m_last  = E - 1;
        m_stall = '0;
        cycle(4'b0110, 1'b1);
        chk("post_rst_lowest", 32'(yumi_o), 32'h2);
        repeat (2) cycle(4'b0000, 1'b1);

        // Stall statistics.
        do_reset();
        cycle(4'b0001, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        chk("stall_5", 32'(stall_cnt_o), 32'(STALL5));
`ifdef BSG_FSB_HOP_OUT_STALL_CNT_EN
        cycle(4'b0001, 1'b0);
        @(negedge clk_i);
        v_i     = '0;
        ready_i = 1'b0;
        repeat (70000) @(negedge clk_i);
        m_stall = 16'hFFFF;
        cycle(4'b0000, 1'b1);
        chk("stall_sat", 32'(stall_cnt_o), 32'h0000FFFF);
`endif
        repeat (2) cycle(4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
